duck_spawn_ctrl: RTL

DUCK_SPAWN_CTRL -- requirements
Module: duck_spawn_ctrl

---
 rtl/duck_pkg.sv | 32 +++
 rtl/duck_spawn_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/duck_pkg.sv
// Shared defaults, widths, FSM encoding and spawn payload for the duck spawner.
package duck_pkg;

  localparam int unsigned SCREEN_W_DEF  = 640;
  localparam int unsigned DUCK_W_DEF    = 32;
  localparam int unsigned MAX_TRIES_DEF = 8;

  localparam int unsigned X_W            = 10;
  localparam int unsigned NIB_W          = 4;
  localparam int unsigned ACC_W          = 12;
  localparam int unsigned PH_W           = 2;
  localparam int unsigned COLLECT_CYCLES = 3;
  localparam int unsigned ST_W           = 2;

  localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [ST_W-1:0] ST_COLLECT = 2'd1;
  localparam logic [ST_W-1:0] ST_CHECK   = 2'd2;
  localparam logic [ST_W-1:0] ST_PRESENT = 2'd3;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic           dir;
    logic           fallback;
  } spawn_t;

  // Right-most legal sprite x position
  function automatic logic [X_W-1:0] xmax_f(input int unsigned screen_w,
                                            input int unsigned duck_w);
    return X_W'(screen_w - duck_w);
  endfunction

endpackage

// File: rtl/duck_spawn_ctrl.sv
// Picks a random on-screen spawn x/direction from LFSR nibbles, retrying
// out-of-range candidates and falling back to mid-screen after MAX_TRIES.
module duck_spawn_ctrl
  import duck_pkg::*;
#(
  parameter int unsigned SCREEN_W  = SCREEN_W_DEF,
  parameter int unsigned DUCK_W    = DUCK_W_DEF,
  parameter int unsigned MAX_TRIES = MAX_TRIES_DEF
) (
  input  logic       clk0,
  input  logic       rst,
  input  logic [3:0] random_bits,
  input  logic       spawn_req,
  input  logic       spawn_ready,
  output logic       spawn_valid,
  output logic [9:0] spawn_x,
  output logic       spawn_dir,
  output logic       spawn_fallback,
  output logic       busy
);

  localparam logic [X_W-1:0]  XMAX      = xmax_f(SCREEN_W, DUCK_W);
  localparam logic [X_W-1:0]  XMID      = XMAX >> 1;
  localparam int unsigned     TRY_W     = (MAX_TRIES < 1) ? 1 : $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(COLLECT_CYCLES - 1);

  logic [ST_W-1:0]  state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  spawn_t           out_q, out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic [X_W-1:0]   cand_x_c;
  logic             cand_dir_c;
  logic [TRY_W-1:0] tries_inc_c;

  assign cand_x_c    = acc_q[X_W-1:0];
  assign cand_dir_c  = acc_q[X_W];
  assign tries_inc_c = tries_q + TRY_W'(1);

  // Next-state, datapath and output-register decode
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    tries_d = tries_q;
    phase_d = phase_q;
    out_d   = out_q;
    valid_d = valid_q;

    case (state_q)
      ST_IDLE: begin
        if (spawn_req) begin
          state_d = ST_COLLECT;
          tries_d = '0;
          phase_d = '0;
        end
      end

      ST_COLLECT: begin
        // Oldest nibble ends up in the top of the accumulator
        acc_d = ACC_W'({acc_q, random_bits});
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          state_d = ST_CHECK;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      ST_CHECK: begin
        if (cand_x_c <= XMAX) begin
          out_d   = '{x: cand_x_c, dir: cand_dir_c, fallback: 1'b0};
          valid_d = 1'b1;
          state_d = ST_PRESENT;
        end else if (tries_inc_c >= TRY_LIMIT) begin
          out_d   = '{x: XMID, dir: cand_dir_c, fallback: 1'b1};
          tries_d = tries_inc_c;
          valid_d = 1'b1;
          state_d = ST_PRESENT;
        end else begin
          tries_d = tries_inc_c;
          state_d = ST_COLLECT;
        end
      end

      ST_PRESENT: begin
        if (spawn_ready) begin
          valid_d = 1'b0;
          if (spawn_req) begin
            state_d = ST_COLLECT;
            tries_d = '0;
            phase_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk0) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      tries_q <= '0;
      phase_q <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      tries_q <= tries_d;
      phase_q <= phase_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign spawn_valid    = valid_q;
  assign spawn_x        = out_q.x;
  assign spawn_dir      = out_q.dir;
  assign spawn_fallback = out_q.fallback;
  assign busy           = busy_q;

endmodule
